// File: rtl/fet_segdriver_pmos_ctrl.sv
// fet_segdriver_pmos_ctrl: segmented high-side PMOS gate sequencer (clk, rst, en, pwm, ls_off, ocp, seg_cnt, dead_cyc, step_cyc -> gate_n active-low per segment, hs_on, fault)
module fet_segdriver_pmos_ctrl #(
  parameter int N_SEG = 8,
  parameter int DT_W = 4,
  parameter int STEP_W = 3,
  localparam int CW = $clog2(N_SEG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pwm,
  input  logic              ls_off,
  input  logic              ocp,
  input  logic [CW-1:0]     seg_cnt,
  input  logic [DT_W-1:0]   dead_cyc,
  input  logic [STEP_W-1:0] step_cyc,
  output logic [N_SEG-1:0]  gate_n,
  output logic              hs_on,
  output logic              fault
);
  typedef enum logic [2:0] {OFF, DEAD, RAMP, ON, FLT} state_t;
  state_t state, state_n;
  logic [DT_W-1:0] dcnt, dcnt_n;
  logic [STEP_W-1:0] scnt, scnt_n;
  logic [CW-1:0] nseg, nseg_n, seg_tgt, tgt_n, seg_clamp;
  logic [N_SEG-1:0] gate_n_n, on_gate;
  logic hs_on_n, fault_n, stop;
  assign seg_clamp = seg_cnt == '0 ? CW'(1) : seg_cnt > CW'(N_SEG) ? CW'(N_SEG) : seg_cnt;
  assign on_gate = ~({N_SEG{1'b1}} >> (CW'(N_SEG) - seg_tgt));
  assign stop = !en || !pwm;
  always_comb begin
    state_n = state;
    dcnt_n = dcnt;
    scnt_n = scnt;
    nseg_n = nseg;
    tgt_n = seg_tgt;
    gate_n_n = '1;
    hs_on_n = 1'b0;
    fault_n = 1'b0;
    if (ocp && state != FLT) begin
      state_n = FLT;
      fault_n = 1'b1;
    end else begin
      case (state)
        OFF:
          if (en && pwm) begin
            state_n = DEAD;
            dcnt_n = dead_cyc;
            tgt_n = seg_clamp;
          end
        DEAD:
          if (stop) state_n = OFF;
          else if (!ls_off) dcnt_n = dead_cyc;
          else if (dcnt == '0) begin
            state_n = RAMP;
            gate_n_n = {N_SEG{1'b1}} << 1;
            scnt_n = step_cyc;
            nseg_n = CW'(1);
          end else dcnt_n = dcnt - 1'b1;
        RAMP:
          if (stop) state_n = OFF;
          else if (nseg == seg_tgt) begin
            state_n = ON;
            gate_n_n = gate_n;
            hs_on_n = 1'b1;
          end else if (scnt == '0) begin
            gate_n_n = gate_n & ~(N_SEG'(1) << nseg);
            nseg_n = nseg + 1'b1;
            scnt_n = step_cyc;
          end else begin
            gate_n_n = gate_n;
            scnt_n = scnt - 1'b1;
          end
        ON:
          if (stop) state_n = OFF;
          else begin
            gate_n_n = on_gate;
            hs_on_n = 1'b1;
          end
        FLT:
          if (!en) state_n = OFF;
          else fault_n = 1'b1;
        default: state_n = OFF;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      dcnt <= '0;
      scnt <= '0;
      nseg <= '0;
      seg_tgt <= CW'(1);
      gate_n <= '1;
      hs_on <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      dcnt <= dcnt_n;
      scnt <= scnt_n;
      nseg <= nseg_n;
      seg_tgt <= tgt_n;
      gate_n <= gate_n_n;
      hs_on <= hs_on_n;
      fault <= fault_n;
    end
  end
endmodule
